cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the team CPU. It fetches each instruction over a valid-handshake instruction-memory port and holds it in an instruction register that feeds the combinational decoder. It then issues one-cycle PC-update and register-write strobes qualified by the decoder's outputs. It sits between instruction memory, the decoder and the PC/register-file datapath, and it owns halt, fault and retired-instruction bookkeeping.

---
 rtl/cpu_seq_pkg.sv | 25 ++
 rtl/cpu_sequencer_if.sv | 28 ++
 rtl/fetch_timeout_ctr.sv | 35 +++
 rtl/cpu_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared types and constants for the CPU control sequencer
//
// Contents:
//   seq_state_t  sequencer FSM states (S_PAUSE is only reachable when the
//                CPU_SEQ_SINGLE_STEP_EN build option is defined)
//   HALT_INSTR   instruction word that stops the sequencer
//   OP_IMM       opcode of immediate ALU ops (shared with the decoder)
//   OP_BRANCH    opcode of conditional branches (shared with the decoder)
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4,
        S_FAULT   = 3'd5,
        S_PAUSE   = 3'd6
    } seq_state_t;

    localparam logic [31:0] HALT_INSTR = 32'h0000_0000;
    localparam logic [6:0]  OP_IMM     = 7'd19;
    localparam logic [6:0]  OP_BRANCH  = 7'd99;

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction-memory fetch handshake bundle
//
// Signals:
//   imem_req    fetch request, driven by the sequencer
//   imem_valid  instruction word valid this cycle, driven by memory
//   imem_rdata  32-bit instruction word, driven by memory
// Modports:
//   master  sequencer side
//   slave   instruction-memory side
interface cpu_sequencer_if;

    logic        imem_req;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - counts missed fetch cycles and flags the timeout
//
// Parameters:
//   TIMEOUT    number of missed cycles that constitutes a timeout (>= 1)
// Ports:
//   clk        system clock
//   i_clear    synchronous clear (highest priority)
//   i_en       one missed cycle this clock
//   o_expired  this missed cycle is the TIMEOUT-th one
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags during the miss that brings the count to TIMEOUT, so the FSM can
    // leave FETCH on that same edge; a valid word in that cycle never counts.
    assign o_expired = i_en && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute control sequencer
//
// Build option: CPU_SEQ_SINGLE_STEP_EN adds the step input and the PAUSE state.
// Parameters:
//   CNT_W        width of the retired-instruction counter
//   TIMEOUT      missed FETCH cycles before FAULT (>= 1)
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        begin/resume execution (IDLE and HALT only)
//   step         single-step release from PAUSE (option only)
//   imem         fetch handshake (master side)
//   instr        instruction register, feeds the decoder
//   dec_regwrite decoder register-write request
//   dec_pcsrc    decoder next-PC select
//   rf_we        register-file write strobe (EXECUTE only)
//   pc_en        PC update strobe (EXECUTE only)
//   pc_sel       next-PC select, meaningful while pc_en is high
//   busy         FETCH, DECODE, EXECUTE or PAUSE
//   halted       in HALT
//   fault        in FAULT
//   retired      executed-instruction count, wraps silently
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    cpu_sequencer_if.master  imem,
    output logic [31:0]      instr,
    input  logic             dec_regwrite,
    input  logic             dec_pcsrc,
    output logic             rf_we,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [31:0]      r_instr;
    logic [CNT_W-1:0] r_retired;
    logic             w_in_fetch;
    logic             w_expired;

    assign w_in_fetch = (r_state == S_FETCH);

    // Holding the counter clear outside FETCH gives a fresh count on every
    // FETCH entry, and the rst term covers the in-flight fetch case.
    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .i_clear   (rst || !w_in_fetch),
        .i_en      (w_in_fetch && !imem.imem_valid),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_in_fetch && imem.imem_valid) begin
                r_instr <= imem.imem_rdata;
            end
            if (r_state == S_EXECUTE) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (imem.imem_valid) w_next_state = S_DECODE;
                else if (w_expired)  w_next_state = S_FAULT;
            end
            S_DECODE: begin
                w_next_state = (r_instr == HALT_INSTR) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
`ifdef CPU_SEQ_SINGLE_STEP_EN
                w_next_state = S_PAUSE;
`else
                w_next_state = S_FETCH;
`endif
            end
`ifdef CPU_SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) w_next_state = S_FETCH;
            end
`endif
            S_HALT: begin
                if (start) w_next_state = S_FETCH;
            end
            S_FAULT: begin
                w_next_state = S_FAULT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        rf_we         = 1'b0;
        pc_en         = 1'b0;
        pc_sel        = 1'b0;
        busy          = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem.imem_req = 1'b1;
                busy          = 1'b1;
            end
            S_DECODE: begin
                busy = 1'b1;
            end
            S_EXECUTE: begin
                busy   = 1'b1;
                pc_en  = 1'b1;
                pc_sel = dec_pcsrc;
                rf_we  = dec_regwrite;
            end
            S_PAUSE: begin
                busy = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign instr   = r_instr;
    assign retired = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;

    localparam logic [31:0] I_ADDI1 = 32'h0010_0093;
    localparam logic [31:0] I_ADDI2 = 32'h0020_0113;
    localparam logic [31:0] I_BNE   = 32'h0020_9463;
    localparam logic [31:0] I_INC   = 32'h0010_8093;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // dut0: CNT_W=4, TIMEOUT=16, memory model with programmable latency
    cpu_sequencer_if if0();
    logic        start0 = 1'b0;
    logic        step0  = 1'b0;
    logic [31:0] instr0;
    logic        dec_rw0, dec_pc0;
    logic        rf_we0, pc_en0, pc_sel0, busy0, halted0, fault0;
    logic [3:0]  retired0;

    logic [31:0] prog [0:31];
    int          mem_idx   = 0;
    int          mem_wait  = 0;
    int          mem_delay = 0;

    assign if0.imem_valid = if0.imem_req && (mem_wait >= mem_delay);
    assign if0.imem_rdata = prog[mem_idx];
    assign dec_rw0 = (instr0[6:0] == OP_IMM);
    assign dec_pc0 = (instr0[6:0] == OP_BRANCH);

    always @(posedge clk) begin
        if (rst) begin
            mem_idx  <= 0;
            mem_wait <= 0;
        end else if (if0.imem_req) begin
            if (if0.imem_valid) begin
                mem_idx  <= mem_idx + 1;
                mem_wait <= 0;
            end else begin
                mem_wait <= mem_wait + 1;
            end
        end
    end

    cpu_sequencer #(.CNT_W(4), .TIMEOUT(16)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .start        (start0),
`ifdef CPU_SEQ_SINGLE_STEP_EN
        .step         (step0),
`endif
        .imem         (if0),
        .instr        (instr0),
        .dec_regwrite (dec_rw0),
        .dec_pcsrc    (dec_pc0),
        .rf_we        (rf_we0),
        .pc_en        (pc_en0),
        .pc_sel       (pc_sel0),
        .busy         (busy0),
        .halted       (halted0),
        .fault        (fault0),
        .retired      (retired0)
    );

    // dut1: CNT_W=32, TIMEOUT=4, memory driven directly by the bench
    cpu_sequencer_if if1();
    logic        start1 = 1'b0;
    logic        step1  = 1'b0;
    logic        valid1 = 1'b0;
    logic [31:0] rdata1 = 32'h0;
    logic [31:0] instr1;
    logic        rf_we1, pc_en1, pc_sel1, busy1, halted1, fault1;
    logic [31:0] retired1;

    assign if1.imem_valid = valid1;
    assign if1.imem_rdata = rdata1;

    cpu_sequencer #(.CNT_W(32), .TIMEOUT(4)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .start        (start1),
`ifdef CPU_SEQ_SINGLE_STEP_EN
        .step         (step1),
`endif
        .imem         (if1),
        .instr        (instr1),
        .dec_regwrite (1'b0),
        .dec_pcsrc    (1'b0),
        .rf_we        (rf_we1),
        .pc_en        (pc_en1),
        .pc_sel       (pc_sel1),
        .busy         (busy1),
        .halted       (halted1),
        .fault        (fault1),
        .retired      (retired1)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start0, then steps until halt/fault or the cycle budget runs out.
    // n counts cycles from the start edge (n=1 is the first FETCH cycle).
    task automatic run0(input int budget, output int n, output int pcs,
                        output int wes, output logic [31:0] sels);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 1; pcs = 0; wes = 0; sels = '0;
        forever begin
            if (pc_en0) begin
                if (pc_sel0) sels[pcs] = 1'b1;
                pcs++;
            end
            if (rf_we0) wes++;
            if (halted0 || fault0 || n >= budget) break;
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int          n, pcs, wes, paused_ok;
    logic [31:0] sels;

    initial begin
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
        rst = 1'b1;
        tick();
        tick();

        check_eq("rst_req",     if0.imem_req, 1'b0);
        check_eq("rst_outs",    {rf_we0, pc_en0, pc_sel0, busy0, halted0, fault0}, 6'b0);
        check_eq("rst_instr",   instr0, 32'h0);
        check_eq("rst_retired", retired0, 4'h0);
        check_eq("rst_fault1",  fault1, 1'b0);
        rst = 1'b0;

`ifdef CPU_SEQ_SINGLE_STEP_EN
        prog[0] = I_ADDI1; prog[1] = I_ADDI2; prog[2] = HALT_INSTR;
        mem_delay = 0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        tick();
        tick();
        check_eq("ss_exec", pc_en0, 1'b1);
        paused_ok = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!if0.imem_req && busy0) paused_ok++;
        end
        check_eq("ss_pause10", paused_ok, 10);
        mem_delay = 3;
        step0 = 1'b1; tick(); step0 = 1'b0;
        check_eq("ss_fetch", if0.imem_req, 1'b1);
        step0 = 1'b1; tick(); step0 = 1'b0;
        check_eq("ss_step_in_fetch", if0.imem_req, 1'b1);
        check_eq("ss_retired", retired0, 4'd1);
        do_reset();
`else
        // zero-wait program: addi, addi, bne, halt
        prog[0] = I_ADDI1; prog[1] = I_ADDI2; prog[2] = I_BNE; prog[3] = HALT_INSTR;
        mem_delay = 0;
        run0(100, n, pcs, wes, sels);
        check_eq("zw_cycles",  n, 12);
        check_eq("zw_pc_en",   pcs, 3);
        check_eq("zw_rf_we",   wes, 2);
        check_eq("zw_pc_sel",  sels, 32'b100);
        check_eq("zw_halted",  halted0, 1'b1);
        check_eq("zw_retired", retired0, 4'd3);
        check_eq("zw_busy",    busy0, 1'b0);

        // resume from HALT with 5 wait cycles per fetch
        prog[4] = I_ADDI2; prog[5] = HALT_INSTR;
        mem_delay = 5;
        run0(100, n, pcs, wes, sels);
        check_eq("ws_cycles",  n, 16);
        check_eq("ws_pc_en",   pcs, 1);
        check_eq("ws_retired", retired0, 4'd4);
        check_eq("ws_fault",   fault0, 1'b0);
        check_eq("ws_halted",  halted0, 1'b1);

        // reset during DECODE of the second instruction
        do_reset();
        mem_delay = 0;
        prog[0] = I_ADDI1; prog[1] = I_ADDI2; prog[2] = HALT_INSTR;
        start0 = 1'b1; tick(); start0 = 1'b0;
        check_eq("st_req_t1", if0.imem_req, 1'b1);
        tick();
        tick();
        tick();
        tick();
        check_eq("md_decode", {busy0, if0.imem_req}, 2'b10);
        check_eq("md_instr",  instr0, I_ADDI2);
        rst = 1'b1;
        tick();
        check_eq("md_rst_outs",  {if0.imem_req, rf_we0, pc_en0, pc_sel0, busy0, halted0, fault0}, 7'b0);
        check_eq("md_rst_instr", instr0, 32'h0);
        check_eq("md_rst_ret",   retired0, 4'h0);
        rst = 1'b0;
        run0(100, n, pcs, wes, sels);
        check_eq("md_re_cycles",  n, 9);
        check_eq("md_re_retired", retired0, 4'd2);

        // 16 instructions on a 4-bit counter wraps to zero
        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = I_INC;
        prog[16] = HALT_INSTR;
        run0(200, n, pcs, wes, sels);
        check_eq("wr_cycles",  n, 51);
        check_eq("wr_pc_en",   pcs, 16);
        check_eq("wr_retired", retired0, 4'd0);
        check_eq("wr_halted",  halted0, 1'b1);
`endif

        // fetch timeout on dut1 (TIMEOUT=4)
        do_reset();
        valid1 = 1'b0; rdata1 = 32'h0;
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick();
        tick();
        tick();
        check_eq("to_c4_fault", fault1, 1'b0);
        check_eq("to_c4_req",   if1.imem_req, 1'b1);
        tick();
        check_eq("to_c5_fault", fault1, 1'b1);
        check_eq("to_c5_req",   {if1.imem_req, busy1}, 2'b00);
        start1 = 1'b1; tick(); start1 = 1'b0;
        check_eq("to_start_ign", {fault1, if1.imem_req}, 2'b10);
        do_reset();
        check_eq("to_rst_clear", fault1, 1'b0);

        // valid in the TIMEOUT-th cycle is still accepted
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick();
        tick();
        tick();
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        check_eq("tb_edge_fault", fault1, 1'b0);
        check_eq("tb_edge_busy",  busy1, 1'b1);
        tick();
        check_eq("tb_edge_halt",  halted1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
